// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
// Module : uart_pkg
// Brief  : Shared UART constants, parity encodings, TX state encoding and
//          a parity helper.
// Rev    : 1.0  initial release
// ============================================================================
package uart_pkg;

  localparam int UART_CLK_FREQ = 11059200;
  localparam int UART_BAUD     = 9600;

  // Parity mode encodings
  localparam int PAR_NONE = 0;
  localparam int PAR_EVEN = 1;
  localparam int PAR_ODD  = 2;

  // Transmitter state encoding
  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_START  = 3'd1;
  localparam logic [2:0] ST_DATA   = 3'd2;
  localparam logic [2:0] ST_PARITY = 3'd3;
  localparam logic [2:0] ST_STOP   = 3'd4;

  typedef enum logic [2:0] {
    S_IDLE   = ST_IDLE,
    S_START  = ST_START,
    S_DATA   = ST_DATA,
    S_PARITY = ST_PARITY,
    S_STOP   = ST_STOP
  } tx_state_e;

  // Parity bit for a byte: even mode makes the total count of ones even.
  function automatic logic parity_bit(input logic [7:0] b, input int mode);
    return (mode == PAR_ODD) ? ~(^b) : (^b);
  endfunction

endpackage
`default_nettype wire

// File: rtl/uart_baud_tick.sv
`default_nettype none
// ============================================================================
// Module : uart_baud_tick
// Brief  : Free-running 0..DIV-1 counter with synchronous clear; tick_o is
//          high in the cycle the count equals DIV-1.
// Rev    : 1.0  initial release
// ============================================================================
module uart_baud_tick #(
  parameter int DIV = 4
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic clr_i,
  output logic tick_o
);

  localparam int CNT_W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CNT_W-1:0] C_LAST = CNT_W'(DIV - 1);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  logic             w_at_last;

  assign w_at_last = (cnt_q == C_LAST);
  assign tick_o    = w_at_last && !clr_i;

  // Next count: hold at zero while cleared, wrap after the last count
  always_comb begin
    cnt_d = cnt_q + CNT_W'(1);
    if (clr_i || w_at_last) begin
      cnt_d = '0;
    end
  end

  // Counter register
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule
`default_nettype wire

// File: rtl/uart_tx_serializer.sv
`default_nettype none
// ============================================================================
// Module : uart_tx_serializer
// Brief  : Byte-serial UART transmitter: start bit, 8 data bits LSB first,
//          optional parity, 1 or 2 stop bits. Start/busy handshake.
// Rev    : 1.0  initial release
// ============================================================================
module uart_tx_serializer
  import uart_pkg::*;
#(
  parameter int CLK_FREQ  = UART_CLK_FREQ,
  parameter int BAUD      = UART_BAUD,
  parameter int PARITY    = PAR_NONE,
  parameter int STOP_BITS = 1
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       tx_start_i,
  input  logic [7:0] tx_data_i,
  output logic       tx_busy_o,
  output logic       tx_done_o,
  output logic       txd_o
);

  localparam int   DIV       = CLK_FREQ / BAUD;
  localparam logic STOP_LAST = 1'(STOP_BITS - 1);

  generate
    if (DIV < 2 || PARITY < 0 || PARITY > 2 || !(STOP_BITS == 1 || STOP_BITS == 2)) begin : g_bad_params
      $error("uart_tx_serializer: illegal DIV/PARITY/STOP_BITS parameter combination");
    end
  endgenerate

  tx_state_e  state_q, state_d;
  logic [7:0] shift_q, shift_d;
  logic [2:0] bit_cnt_q, bit_cnt_d;
  logic       stop_cnt_q, stop_cnt_d;
  logic       par_q, par_d;
  logic       txd_q, txd_d;
  logic       busy_q, busy_d;
  logic       done_q, done_d;

  logic       w_baud_clr;
  logic       w_baud_tick;

  // The bit timer is held at zero while idle so every frame starts aligned
  assign w_baud_clr = (state_q == S_IDLE);

  uart_baud_tick #(
    .DIV (DIV)
  ) u_baud_tick (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .clr_i  (w_baud_clr),
    .tick_o (w_baud_tick)
  );

  // Next-state logic; txd/busy/done are computed one step ahead and registered
  always_comb begin
    state_d    = state_q;
    shift_d    = shift_q;
    bit_cnt_d  = bit_cnt_q;
    stop_cnt_d = stop_cnt_q;
    par_d      = par_q;
    txd_d      = txd_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (tx_start_i) begin
          shift_d = tx_data_i;
          par_d   = parity_bit(tx_data_i, PARITY);
          state_d = S_START;
          txd_d   = 1'b0;
          busy_d  = 1'b1;
        end
      end
      S_START: begin
        if (w_baud_tick) begin
          state_d   = S_DATA;
          bit_cnt_d = 3'd0;
          txd_d     = shift_q[0];
        end
      end
      S_DATA: begin
        if (w_baud_tick) begin
          shift_d   = {1'b0, shift_q[7:1]};
          bit_cnt_d = bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'd7) begin
            if (PARITY != PAR_NONE) begin
              state_d = S_PARITY;
              txd_d   = par_q;
            end else begin
              state_d    = S_STOP;
              stop_cnt_d = 1'b0;
              txd_d      = 1'b1;
            end
          end else begin
            txd_d = shift_q[1];
          end
        end
      end
      S_PARITY: begin
        if (w_baud_tick) begin
          state_d    = S_STOP;
          stop_cnt_d = 1'b0;
          txd_d      = 1'b1;
        end
      end
      S_STOP: begin
        if (w_baud_tick) begin
          if (stop_cnt_q == STOP_LAST) begin
            state_d = S_IDLE;
            busy_d  = 1'b0;
            done_d  = 1'b1;
            txd_d   = 1'b1;
          end else begin
            stop_cnt_d = stop_cnt_q + 1'b1;
          end
        end
      end
      default: begin
        state_d = S_IDLE;
        txd_d   = 1'b1;
        busy_d  = 1'b0;
      end
    endcase
  end

  // State and output registers; reset drops any frame in flight
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= S_IDLE;
      shift_q    <= '0;
      bit_cnt_q  <= '0;
      stop_cnt_q <= 1'b0;
      par_q      <= 1'b0;
      txd_q      <= 1'b1;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      shift_q    <= shift_d;
      bit_cnt_q  <= bit_cnt_d;
      stop_cnt_q <= stop_cnt_d;
      par_q      <= par_d;
      txd_q      <= txd_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  assign txd_o     = txd_q;
  assign tx_busy_o = busy_q;
  assign tx_done_o = done_q;

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_serializer.sv
`default_nettype none
// ============================================================================
// Module : tb_uart_tx_serializer
// Brief  : Directed self-checking bench for uart_tx_serializer. Five
//          instances cover parity none/even/odd, two stop bits and the
//          default baud divider.
// Rev    : 1.0  initial release
// ============================================================================
module tb_uart_tx_serializer;

  logic       clk;
  logic       rst_n;
  logic [4:0] start;
  logic [7:0] data [5];
  logic [4:0] busy;
  logic [4:0] done;
  logic [4:0] txd;

  int n_assert = 0;
  int n_fail   = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // u0: no parity, 1 stop; u1: even; u2: odd; u3: 2 stop bits; u4: defaults
  uart_tx_serializer #(.CLK_FREQ(16), .BAUD(4), .PARITY(0), .STOP_BITS(1)) u0 (
    .clk_i(clk), .rst_ni(rst_n), .tx_start_i(start[0]), .tx_data_i(data[0]),
    .tx_busy_o(busy[0]), .tx_done_o(done[0]), .txd_o(txd[0]));
  uart_tx_serializer #(.CLK_FREQ(16), .BAUD(4), .PARITY(1), .STOP_BITS(1)) u1 (
    .clk_i(clk), .rst_ni(rst_n), .tx_start_i(start[1]), .tx_data_i(data[1]),
    .tx_busy_o(busy[1]), .tx_done_o(done[1]), .txd_o(txd[1]));
  uart_tx_serializer #(.CLK_FREQ(16), .BAUD(4), .PARITY(2), .STOP_BITS(1)) u2 (
    .clk_i(clk), .rst_ni(rst_n), .tx_start_i(start[2]), .tx_data_i(data[2]),
    .tx_busy_o(busy[2]), .tx_done_o(done[2]), .txd_o(txd[2]));
  uart_tx_serializer #(.CLK_FREQ(16), .BAUD(4), .PARITY(0), .STOP_BITS(2)) u3 (
    .clk_i(clk), .rst_ni(rst_n), .tx_start_i(start[3]), .tx_data_i(data[3]),
    .tx_busy_o(busy[3]), .tx_done_o(done[3]), .txd_o(txd[3]));
  uart_tx_serializer u4 (
    .clk_i(clk), .rst_ni(rst_n), .tx_start_i(start[4]), .tx_data_i(data[4]),
    .tx_busy_o(busy[4]), .tx_done_o(done[4]), .txd_o(txd[4]));

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Pulse tx_start for one cycle; returns at the negedge of frame cycle 1
  task automatic launch(input int k, input logic [7:0] d);
    data[k]  = d;
    start[k] = 1'b1;
    @(negedge clk);
    start[k] = 1'b0;
  endtask

  // Check every cycle of a frame; bit i of exp is the i-th bit on the line.
  // Returns at the negedge of the first cycle after the frame.
  task automatic expect_frame(input int k, input logic [11:0] exp, input int nbits,
                              input int dv, input bit scramble);
    for (int b = 0; b < nbits; b++) begin
      for (int c = 0; c < dv; c++) begin
        check("txd_bit", {31'd0, txd[k]}, {31'd0, exp[b]});
        check("busy_in_frame", {31'd0, busy[k]}, 32'd1);
        check("done_in_frame", {31'd0, done[k]}, 32'd0);
        if (scramble) data[k] = 8'($urandom);
        @(negedge clk);
      end
    end
    check("busy_after_frame", {31'd0, busy[k]}, 32'd0);
    check("done_pulse", {31'd0, done[k]}, 32'd1);
  endtask

  // After a frame: done must drop and the line stays idle
  task automatic expect_idle(input int k);
    @(negedge clk);
    check("done_one_shot", {31'd0, done[k]}, 32'd0);
    check("txd_idle", {31'd0, txd[k]}, 32'd1);
    check("busy_idle", {31'd0, busy[k]}, 32'd0);
  endtask

  initial begin
    rst_n = 1'b0;
    start = '0;
    for (int i = 0; i < 5; i++) data[i] = 8'h00;

    // Reset state of every instance
    repeat (2) @(negedge clk);
    for (int k = 0; k < 5; k++) begin
      check("rst_txd", {31'd0, txd[k]}, 32'd1);
      check("rst_busy", {31'd0, busy[k]}, 32'd0);
      check("rst_done", {31'd0, done[k]}, 32'd0);
    end
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // 8'hA5, no parity: 0,1,0,1,0,0,1,0,1,1
    launch(0, 8'hA5);
    expect_frame(0, 12'h34A, 10, 4, 1'b0);
    expect_idle(0);

    // 8'h07 even parity: data 1,1,1,0,0,0,0,0 parity 1
    launch(1, 8'h07);
    expect_frame(1, 12'h60E, 11, 4, 1'b0);
    expect_idle(1);

    // 8'h07 odd parity: parity 0
    launch(2, 8'h07);
    expect_frame(2, 12'h40E, 11, 4, 1'b0);
    expect_idle(2);

    // 8'h00 with two stop bits
    launch(3, 8'h00);
    expect_frame(3, 12'h600, 11, 4, 1'b0);
    expect_idle(3);

    // Default divider 1152, 8'h55: 0,1,0,1,0,1,0,1,0,1
    launch(4, 8'h55);
    expect_frame(4, 12'h2AA, 10, 1152, 1'b0);
    expect_idle(4);

    // tx_start held high, data scrambled every cycle while busy
    @(negedge clk);
    data[0]  = 8'h3C;
    start[0] = 1'b1;
    @(negedge clk);
    expect_frame(0, 12'h278, 10, 4, 1'b1);
    // busy is low here; this byte is accepted on the next edge
    data[0] = 8'hC3;
    @(negedge clk);
    expect_frame(0, 12'h386, 10, 4, 1'b1);
    start[0] = 1'b0;
    for (int i = 0; i < 6; i++) expect_idle(0);

    // Asynchronous reset in cycle 13 of a frame
    launch(0, 8'hA5);
    repeat (12) @(negedge clk);
    check("busy_before_rst", {31'd0, busy[0]}, 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_txd", {31'd0, txd[0]}, 32'd1);
    check("async_rst_busy", {31'd0, busy[0]}, 32'd0);
    check("async_rst_done", {31'd0, done[0]}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 8; i++) expect_idle(0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/uart_tx_serializer.md
Name: uart_tx_serializer

Overview:
- Byte-serial UART transmitter that drains the TX byte FIFO in the memory/UART controller and drives the board `txd` pin.
- Consumes a start/busy handshake: the controller pops its FIFO whenever `tx_start` is asserted while `tx_busy` is low.
- Generates its own baud timing from the system clock and frames each byte as start bit, 8 data bits LSB-first, optional parity bit, then 1 or 2 stop bits.

Parameters:
- CLK_FREQ, 11059200, system clock frequency in Hz.
- BAUD, 9600, line rate in bit/s. The divider is DIV = CLK_FREQ/BAUD, integer-truncated; 1152 at the defaults.
- PARITY, 0, parity mode: 0 = none, 1 = even, 2 = odd.
- STOP_BITS, 1, number of stop bits; 1 or 2.

Ports:
- clk  in  1  system clock; all state on the rising edge.
- rst  in  1  asynchronous, active-low reset.
- tx_start  in  1  request to send `tx_data`; sampled every cycle.
- tx_data  in  8  byte to send; valid in the cycle `tx_start` is high (first-word-fall-through FIFO output).
- tx_busy  out  1  high while a frame is in progress; registered.
- tx_done  out  1  one-cycle pulse when a frame's last stop bit completes.
- txd  out  1  serial line; idles high; registered.

Behaviour:
- Reset (rst=0, asynchronous): state=IDLE, txd=1, tx_busy=0, tx_done=0, baud_cnt=0, bit_cnt=0, shift register cleared.
- Reset mid-frame: the line returns to 1 immediately and the byte is dropped. No partial frame resumes after reset.

State machine:
- IDLE
  - If tx_start=1: latch tx_data into the shift register, compute parity from the latched byte, clear baud_cnt, go to START.
  - In the same accept edge, register tx_busy=1 and txd=0.
  - The producer therefore sees tx_busy=1 from the cycle after acceptance. Exactly one FIFO pop occurs per frame.
- START
  - Hold txd=0 for DIV cycles, then go to DATA with bit_cnt=0.
- DATA
  - txd = shift[0]; each bit is held DIV cycles.
  - At the end of each bit: shift right, bit_cnt+1.
  - After bit_cnt reaches 7: go to PARITY if PARITY≠0, else go to STOP.
- PARITY
  - txd = XOR of the data byte (even mode) or its complement (odd mode); held DIV cycles, then go to STOP.
- STOP
  - txd=1 for STOP_BITS×DIV cycles.
  - On the final cycle: register tx_done=1 for one cycle, tx_busy=0, go to IDLE.

Timing and arithmetic:
- baud_cnt counts 0..DIV-1; a bit ends on the cycle baud_cnt=DIV-1, and the counter then wraps to 0.
- baud_cnt width is clog2(DIV). bit_cnt is 3 bits for data; the stop-bit count is tracked separately.
- Frame length is exactly (1+8+P+STOP_BITS)×DIV cycles from the first txd=0 cycle, where P=1 if PARITY≠0.
- Latency: txd falls on the edge that samples tx_start=1 (start bit visible in cycle N+1 for request in cycle N).

Boundary conditions:
- tx_start while busy: ignored. tx_data changes while busy have no effect.
- Back-to-back frames: tx_busy is low for at least one cycle between frames. If tx_start=1 in that cycle, the next start bit follows immediately, giving a single idle cycle of txd=1 beyond the stop bits.
- tx_start held high continuously: one frame per accept, no duplicates.
- Illegal parameters: DIV<2, PARITY>2 or STOP_BITS∉{1,2} stop elaboration via a generate-time error.

Decomposition:
- Shared package `uart_pkg`:
  - UART_CLK_FREQ=11059200, UART_BAUD=9600.
  - Parity encodings PAR_NONE/PAR_EVEN/PAR_ODD.
  - FSM state encoding (IDLE, START, DATA, PARITY, STOP) as localparam constants.
- One sub-module, `uart_baud_tick`:
  - Counter with synchronous clear; emits a tick on the cycle count=DIV-1.
  - The receiver side will reuse it with a DIV/16 oversample.

Test Plan (benches use CLK_FREQ=16, BAUD=4, hence DIV=4):
- PARITY=0, STOP_BITS=1; pulse tx_start with tx_data=8'hA5 → txd sequence 0,1,0,1,0,0,1,0,1,1 (each held 4 cycles); tx_busy high for exactly 40 cycles; tx_done pulses once at cycle 40.
- PARITY=1, tx_data=8'h07 → parity bit 1; PARITY=2 with the same byte → parity bit 0; frame length 44 cycles.
- STOP_BITS=2, tx_data=8'h00 → eight 0 data bits, then txd=1 for 8 cycles; tx_busy high 44 cycles.
- tx_start held high with tx_data changing every cycle during a frame → only the byte present on the accept cycle is sent; the next accept occurs exactly one cycle after tx_busy falls; no extra frames.
- Assert rst=0 at cycle 13 of a frame → txd=1, tx_busy=0, tx_done=0 immediately (asynchronous); after release with tx_start=0, the line stays at 1.
- Defaults (DIV=1152), send 8'h55 → each bit lasts 1152 cycles; total frame 11520 cycles.
